ccg_bist_harness: RTL
=====================

// Module: ccg_bist_harness
// PURPOSE
//  Parametrised self-test harness for generated combinational benchmark cores (CCGRCG family).
//  Drives the core's primary inputs from a seeded LFSR for a programmable pattern count.
//  Compacts the core's primary outputs into a MISR signature, so dataset circuits can be
//  compared by signature. The core is external: stim_o feeds its inputs, resp_i returns its outputs.
// PARAMETERS
//  N_IN      15  core input count = LFSR width (legal 3..32)
//  N_OUT     12  core output count = MISR width (legal 3..32)
//  CNT_W     16  pattern-counter width
//  RESP_LAT  1   cycles from stim_o change to matching resp_i (legal 0..3; 0 = purely combinational core)
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous, active-high reset
//  start_i      in   1       start a run (sampled in IDLE only)
//  seed_i       in   N_IN    LFSR seed; 0 is replaced by all-ones
//  num_pat_i    in   CNT_W   patterns to apply, sampled with start_i
//  stim_o       out  N_IN    current pattern (LFSR register)
//  resp_i       in   N_OUT   core response
//  busy_o       out  1       high in RUN and DRAIN
//  done_o       out  1       one-cycle pulse at end of run
//  sig_o        out  N_OUT   MISR signature
//  sig_valid_o  out  1       sig_o final; held until next accepted start or rst
//  pat_cnt_o    out  CNT_W   patterns issued in the current/last run
// BEHAVIOUR
//  Reset: state IDLE; stim_o, sig_o, pat_cnt_o = 0; busy_o, done_o, sig_valid_o = 0.
//  FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  - IDLE, start_i=1, num_pat_i!=0: lfsr<=seed (or all-ones), misr<=0, cnt<=0, sig_valid<=0, ->RUN.
//  - IDLE, start_i=1, num_pat_i==0: misr<=0, cnt<=0, ->DONE (busy_o never rises).
//  - RUN: one pattern per cycle; cnt++ each edge. LFSR advances on every RUN edge except
//    the last, so stim_o holds the last pattern afterwards. After num_pat cycles: ->DRAIN,
//    or ->DONE if RESP_LAT=0.
//  - DRAIN: RESP_LAT cycles; no new patterns, pending responses absorbed. Then ->DONE.
//  - DONE: done_o=1, sig_valid_o<=1, ->IDLE.
//  - Timing: done_o high in cycle num_pat+RESP_LAT+1 after the start edge.
//  - start_i is ignored outside IDLE; no queueing.
//  LFSR (Fibonacci, shifts left): fb = ^(lfsr & TAPS(N_IN)); next = {lfsr[N_IN-2:0], fb}.
//  MISR: next = {misr[N_OUT-2:0], ^(misr & TAPS(N_OUT))} ^ resp_i.
//  Absorption: resp_i is absorbed only on edges where a RESP_LAT-deep valid shift register
//    tags a live pattern. Exactly num_pat responses are absorbed; responses before pattern 0
//    and after the last are not absorbed.
//  TAPS: 15 -> 15'h6000 (x^15+x^14+1); 12 -> 12'hE08 (x^12+x^11+x^10+x^4+1).
//  rst in any state aborts the run and restores reset values on the next edge.
//  Counter: num_pat up to 2^CNT_W-1; pat_cnt_o saturates at num_pat and never wraps.
// STRUCTURE
//  Package ccg_bist_pkg holds:
//   - state enum {IDLE, RUN, DRAIN, DONE};
//   - function ccg_lfsr_taps(width), the primitive-polynomial mask table for 3..32;
//   - RESP_LAT_MAX = 3.
//  One sub-module: ccg_misr (N_OUT, ce, clr, d_i, sig_o). LFSR, counter, latency
//  shift register and FSM stay in the top.
// TESTING (N_IN=15, N_OUT=12 unless stated)
//  1 seed=0001, num_pat=3, RESP_LAT=1, resp_i=0 -> stim_o 0001,0002,0004; done_o at start+5; sig_o=000.
//  2 RESP_LAT=0, resp_i=stim_o[11:0], seed=0001, num_pat=3 -> sig_o=004, pat_cnt_o=3, sig_valid_o=1.
//  3 RESP_LAT=0, resp_i=800 constant, num_pat=2 -> MISR 800 then 801; sig_o=801.
//  4 seed=0000, num_pat=1 -> first stim_o=7FFF; num_pat=0 -> done_o next cycle, busy_o stays 0, sig_o=000.
//  5 start_i pulsed mid-RUN -> ignored, run completes as originally sampled;
//    rst asserted mid-RUN -> all outputs at reset values next cycle; a fresh start then repeats test 1 results.
//  6 RESP_LAT=3, response tagged by pattern index -> exactly num_pat absorptions
//    (scoreboard MISR model matches); back-to-back start in the cycle after done_o is accepted.

Source files
------------

// File: rtl/ccg_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ccg_bist_pkg
// Brief    : Shared types and polynomial table for the CCG BIST harness
// Revision : 1.0
// ============================================================================
package ccg_bist_pkg;

    localparam int RESP_LAT_MAX = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ccg_state_e;

    // Primitive-polynomial feedback masks; bit k set means x^(k+1) is a tap.
    function automatic logic [31:0] ccg_lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0E08;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ccg_bist_harness_misr.sv
`default_nettype none
// ============================================================================
// Module   : ccg_misr
// Brief    : Multiple-input signature register compacting core responses
// Revision : 1.0
// ============================================================================
module ccg_misr
    import ccg_bist_pkg::*;
#(
    parameter int N_OUT = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             clr,
    input  logic [N_OUT-1:0] d_i,
    output logic [N_OUT-1:0] sig_o
);

    localparam logic [N_OUT-1:0] c_taps = N_OUT'(ccg_lfsr_taps(N_OUT));

    logic [N_OUT-1:0] r_sig;

    // Clear wins over capture so a new run always starts from a zero signature.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_sig <= '0;
        end else if (ce) begin
            r_sig <= {r_sig[N_OUT-2:0], ^(r_sig & c_taps)} ^ d_i;
        end
    end

    assign sig_o = r_sig;

endmodule
`default_nettype wire

// File: rtl/ccg_bist_harness.sv
`default_nettype none
// ============================================================================
// Module   : ccg_bist_harness
// Brief    : Seeded LFSR stimulus and MISR compaction for external CCGRCG cores
// Revision : 1.0
// ============================================================================
module ccg_bist_harness
    import ccg_bist_pkg::*;
#(
    parameter int N_IN     = 15,
    parameter int N_OUT    = 12,
    parameter int CNT_W    = 16,
    parameter int RESP_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [N_IN-1:0]  seed_i,
    input  logic [CNT_W-1:0] num_pat_i,
    output logic [N_IN-1:0]  stim_o,
    input  logic [N_OUT-1:0] resp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [N_OUT-1:0] sig_o,
    output logic             sig_valid_o,
    output logic [CNT_W-1:0] pat_cnt_o
);

    localparam int              c_lat        = (RESP_LAT > RESP_LAT_MAX) ? RESP_LAT_MAX : RESP_LAT;
    localparam logic [N_IN-1:0] c_lfsr_taps  = N_IN'(ccg_lfsr_taps(N_IN));
    localparam logic [1:0]      c_drain_last = 2'(c_lat - 1);

    ccg_state_e       r_state;
    ccg_state_e       w_state_nxt;
    logic [N_IN-1:0]  r_lfsr;
    logic [N_IN-1:0]  w_lfsr_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_num_pat;
    logic [1:0]       r_drain;
    logic             r_sig_valid;
    logic             w_accept;
    logic             w_live;
    logic             w_last;
    logic             w_absorb;
    logic             w_busy;
    logic             w_done;

    assign w_accept   = (r_state == IDLE) && start_i;
    assign w_live     = (r_state == RUN);
    assign w_last     = w_live && (r_cnt == (r_num_pat - CNT_W'(1)));
    assign w_lfsr_nxt = {r_lfsr[N_IN-2:0], ^(r_lfsr & c_lfsr_taps)};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = (num_pat_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = (c_lat == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                w_busy = 1'b1;
                if (r_drain == c_drain_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The LFSR stays put on the final RUN edge so stim_o keeps the last pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr      <= '0;
            r_cnt       <= '0;
            r_num_pat   <= '0;
            r_drain     <= '0;
            r_sig_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_num_pat   <= num_pat_i;
                        r_cnt       <= '0;
                        r_sig_valid <= 1'b0;
                        if (num_pat_i != '0) begin
                            r_lfsr <= (seed_i == '0) ? '1 : seed_i;
                        end
                    end
                end
                RUN: begin
                    r_drain <= '0;
                    if (r_cnt != r_num_pat) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (!w_last) begin
                        r_lfsr <= w_lfsr_nxt;
                    end
                end
                DRAIN: r_drain <= r_drain + 2'd1;
                DONE:  r_sig_valid <= 1'b1;
                default: ;
            endcase
        end
    end

    // A RUN cycle tags a live pattern; the tag reaches the MISR when its response does.
    generate
        if (c_lat == 0) begin : g_lat0
            assign w_absorb = w_live;
        end else begin : g_latn
            logic [c_lat-1:0] r_tag;
            logic [c_lat:0]   w_tag_chain;

            assign w_tag_chain = {r_tag, w_live};

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tag <= '0;
                end else begin
                    r_tag <= w_tag_chain[c_lat-1:0];
                end
            end

            assign w_absorb = w_tag_chain[c_lat];
        end
    endgenerate

    ccg_misr #(
        .N_OUT (N_OUT)
    ) u_misr (
        .clk   (clk),
        .rst   (rst),
        .ce    (w_absorb),
        .clr   (w_accept),
        .d_i   (resp_i),
        .sig_o (sig_o)
    );

    assign stim_o      = r_lfsr;
    assign busy_o      = w_busy;
    assign done_o      = w_done;
    assign sig_valid_o = r_sig_valid;
    assign pat_cnt_o   = r_cnt;

endmodule
`default_nettype wire
